tug_of_war_field: RTL

- Playfield stage of the two-player tug-of-war game.
- Sits directly downstream of the two per-player key press-pulse detectors and consumes their one-cycle pulses.
- Moves a single lit LED left or right, detects when a player pulls the light off their end, and keeps per-player round scores.
- Drives the LED bar and the score / winner indicators, which feed the HEX display decoders.

---
 rtl/tug_of_war_field.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: moves a single lit LED on L/R press pulses, detects
// a pull off either end, and keeps per-player round scores up to MAX_SCORE.
//
// state | meaning
// PLAY  | round in progress, one LED lit at pos
// LWIN  | left took the round, waiting for restart
// RWIN  | right took the round, waiting for restart
// OVER  | a player reached MAX_SCORE, only reset leaves
module tug_of_war_field #(
  parameter int NUM_LEDS  = 9,
  parameter int SCORE_W   = 3,
  parameter int MAX_SCORE = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  input  logic                restart,
  output logic [NUM_LEDS-1:0] leds,
  output logic                l_win,
  output logic                r_win,
  output logic [SCORE_W-1:0]  l_score,
  output logic [SCORE_W-1:0]  r_score,
  output logic                game_over
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0]       CENTER     = PW'(NUM_LEDS / 2);
  localparam logic [PW-1:0]       LAST       = PW'(NUM_LEDS - 1);
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = SCORE_W'(MAX_SCORE);
  localparam logic [NUM_LEDS-1:0] LED_CENTER = NUM_LEDS'(1) << (NUM_LEDS / 2);

  typedef enum logic [1:0] {PLAY, LWIN, RWIN, OVER} state_t;

  state_t               state, state_d;
  logic [PW-1:0]        pos, pos_d;
  logic [NUM_LEDS-1:0]  leds_d;
  logic                 l_win_d, r_win_d, over_d;
  logic [SCORE_W-1:0]   l_score_d, r_score_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      pos       <= CENTER;
      leds      <= LED_CENTER;
      l_win     <= 1'b0;
      r_win     <= 1'b0;
      l_score   <= '0;
      r_score   <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      pos       <= pos_d;
      leds      <= leds_d;
      l_win     <= l_win_d;
      r_win     <= r_win_d;
      l_score   <= l_score_d;
      r_score   <= r_score_d;
      game_over <= over_d;
    end
  end

  always_comb begin
    state_d   = state;
    pos_d     = pos;
    l_win_d   = l_win;
    r_win_d   = r_win;
    l_score_d = l_score;
    r_score_d = r_score;
    over_d    = game_over;
    case (state)
      PLAY: begin
        // restart outranks presses; a simultaneous L+R press is a tie
        if (restart) begin
          pos_d = CENTER;
        end else if (L && !R) begin
          if (pos == LAST) begin
            l_score_d = l_score + SCORE_W'(1);
            l_win_d   = 1'b1;
            if (l_score_d == SCORE_MAX) begin
              state_d = OVER;
              over_d  = 1'b1;
            end else begin
              state_d = LWIN;
            end
          end else begin
            pos_d = pos + PW'(1);
          end
        end else if (R && !L) begin
          if (pos == '0) begin
            r_score_d = r_score + SCORE_W'(1);
            r_win_d   = 1'b1;
            if (r_score_d == SCORE_MAX) begin
              state_d = OVER;
              over_d  = 1'b1;
            end else begin
              state_d = RWIN;
            end
          end else begin
            pos_d = pos - PW'(1);
          end
        end
      end
      LWIN, RWIN: begin
        if (restart) begin
          state_d = PLAY;
          pos_d   = CENTER;
          l_win_d = 1'b0;
          r_win_d = 1'b0;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
        pos_d   = CENTER;
      end
    endcase

    leds_d = '0;
    if (state_d == PLAY) leds_d[pos_d] = 1'b1;
  end

endmodule
